mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage RISC-V pipeline. It holds the EX/MEM pipeline register and drives loads and stores onto a ready/req data-memory port. It sizes byte lanes and sign- or zero-extends load data. It produces the MEM/WB register together with the two forwarding values (`EX_MEM_ALU`, `MEM_WB_Data`) that the EX stage's forwarding muxes consume. It stalls the upstream pipeline while a data-memory access is outstanding.

## Interface
- `DMEM_TIMEOUT`, 255: maximum cycles spent waiting for `dmem_ready`. 0 disables the timeout.

- `clk` in 1: clock.
- `reset` in 1: synchronous reset, active-high.
- `ex_valid` in 1: EX output holds a real instruction (0 = bubble).
- `MemRead`, `MemWrite`, `RegWrite`, `MemtoReg` in 1 each: control bits from EX.
- `Funct3` in 3: access size and signedness.
- `Rd_in` in 5: destination register.
- `ALUResult` in 32: EX result, used as the byte address for memory ops.
- `ForwardedB` in 32: forwarded store data.
- `mem_stall` out 1: freeze PC, IF/ID, ID/EX and the EX/MEM capture.
- `EX_MEM_ALU` out 32, `EX_MEM_Rd` out 5, `EX_MEM_RegWrite` out 1: EX/MEM register contents, used for forwarding.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32, `dmem_wdata` out 32, `dmem_be` out 4: data-memory request channel.
- `dmem_ready` in 1, `dmem_rdata` in 32: data-memory completion and read data.
- `MEM_WB_valid`, `MEM_WB_RegWrite` out 1 each; `MEM_WB_Rd` out 5; `MEM_WB_Data` out 32: MEM/WB register.
- `misalign_err`, `timeout_err` out 1 each: one-cycle error pulses, aligned with the MEM/WB write of the offending instruction.

## Operation
- **EX/MEM capture.** At each edge with `mem_stall`=0, the register loads `em_valid`=`ex_valid` plus all EX fields.
  - `EX_MEM_RegWrite` = `em_valid` & `RegWrite`.
  - Load-use hazards remain the upstream hazard unit's responsibility.
- **FSM states.**
  - IDLE.
  - ACCESS: the EX/MEM register holds an aligned memory op that has not completed.
- **Transitions.**
  - IDLE→ACCESS at the capture edge of a valid, aligned op with `MemRead`|`MemWrite`.
  - ACCESS→IDLE at the edge where `dmem_ready`=1, or where the timeout fires.
  - If a new aligned memory op is captured on that same edge, the state stays ACCESS.
- **Request outputs.**
  - `dmem_req` = (state==ACCESS).
  - `dmem_we` = `MemWrite`.
  - `dmem_addr` = {`ALUResult[31:2]`, 2'b00}.
  - All are driven from registered state and fields only, never from `dmem_ready`.
- **Stall.** `mem_stall` = ACCESS & !`dmem_ready` & !timeout_hit. A memory with `dmem_ready` tied high therefore gives zero stall cycles.
- **Stores**, with a = `ALUResult[1:0]`:
  - `Funct3`=000 (SB): `be`=4'b0001<<a, `wdata`={4{B[7:0]}}.
  - `Funct3`=001 (SH): `be`=4'b0011<<{a[1],1'b0}, `wdata`={2{B[15:0]}}.
  - 010 and any other value: `be`=4'b1111, `wdata`=B.
- **Loads.** Select the lane from `dmem_rdata` by a, then extend:
  - 000 (LB) sign-extend; 100 (LBU) zero-extend.
  - 001 (LH) sign-extend; 101 (LHU) zero-extend.
  - 010 and any other value: full word.
- **Misalignment.** Word access with a≠0, or halfword access with a[0]=1:
  - No request is issued and the state stays IDLE.
  - At the next edge MEM/WB is written with `RegWrite` forced to 0, and `misalign_err`=1.
- **MEM/WB write.**
  - Non-memory or misaligned op: written at the edge after capture.
  - Memory op: written at the completion edge.
  - `MEM_WB_Data` = `MemtoReg` ? extended load data : `ALUResult`.
  - While stalled, and when `em_valid`=0, MEM/WB is written as a bubble: `valid`=0, `RegWrite`=0, and `Data`/`Rd` hold their previous values.
- **Timeout.**
  - The counter clears on entering ACCESS and increments each ACCESS cycle with !`dmem_ready`.
  - timeout_hit = (`DMEM_TIMEOUT`≠0) & (count==`DMEM_TIMEOUT`-1) & !`dmem_ready`.
  - On hit the op completes with read data taken as 0 and `RegWrite` forced to 0, and `timeout_err`=1.
  - `dmem_ready` and the timeout in the same cycle: the ready completion wins and no error is raised.

## Timing
- **Reset.**
  - All outputs are 0: `mem_stall`, `dmem_*`, `EX_MEM_*`, `MEM_WB_*`, both error pulses.
  - State returns to IDLE and the counter clears.
- **Reset during ACCESS.** `dmem_req` drops in the cycle after the reset edge, and the aborted op never reaches MEM/WB.
- **Latency.**
  - ALU op: EX output → `MEM_WB_*` in 2 edges.
  - Load with k wait cycles (`dmem_ready` low for k ACCESS cycles): 2+k edges, with `mem_stall` high for exactly k cycles.
- **Handshake.** `dmem_req`, `addr`, `we`, `be` and `wdata` stay stable until the cycle in which `dmem_ready`=1. `dmem_rdata` is sampled only in that cycle.
- **Back-to-back ops.** Consecutive memory ops with `dmem_ready`=1 complete one per cycle, with `dmem_req` held continuously high.

## Test plan
- **ALU pass-through.** `ex_valid`=1, `RegWrite`=1, `ALUResult`=0x1234, `Rd`=5, no memory op → `EX_MEM_ALU`=0x1234 after edge 1. After edge 2: `MEM_WB_Data`=0x1234, `Rd`=5, `RegWrite`=1, `mem_stall` never set.
- **SB with wait states.** SB to address 0x1003, B=0xAB, `dmem_ready` low for 3 cycles → `dmem_addr`=0x1000, `be`=1000, `wdata`=0xABABABAB, `mem_stall` high exactly 3 cycles, `dmem_req` drops after the ready cycle.
- **LB / LHU.** LB at 0x2001 with `rdata`=0x0000_8000, `ready`=1 → `MEM_WB_Data`=0xFFFF_FF80. LHU at 0x2002 with `rdata`=0xBEEF_0000 → 0x0000_BEEF.
- **Misaligned LW.** LW at 0x3002 → no `dmem_req`. MEM/WB written with `RegWrite`=0, `misalign_err` 1-cycle pulse, no stall.
- **Timeout.** `DMEM_TIMEOUT`=4, load with `dmem_ready` stuck low → stall for 3 cycles. Completion then occurs with `timeout_err`=1 and `RegWrite`=0, and the next instruction proceeds.
- **Reset mid-access.** `reset` asserted during ACCESS → `dmem_req`=0 after the edge and every output equals its reset value. A subsequent ALU op completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, data-memory request/response handling,
// byte-lane steering, load extension and the MEM/WB register.
module mem_stage #(
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic [2:0]  Funct3,
  input  logic [4:0]  Rd_in,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ForwardedB,
  output logic        mem_stall,
  output logic [31:0] EX_MEM_ALU,
  output logic [4:0]  EX_MEM_Rd,
  output logic        EX_MEM_RegWrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        MEM_WB_valid,
  output logic        MEM_WB_RegWrite,
  output logic [4:0]  MEM_WB_Rd,
  output logic [31:0] MEM_WB_Data,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam int unsigned CNT_W = (DMEM_TIMEOUT < 3) ? 1 : $clog2(DMEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DMEM_TIMEOUT - 1);
  localparam logic TMO_EN = (DMEM_TIMEOUT != 0);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  count, count_next;

  logic              em_valid, em_memread, em_memwrite, em_regwrite, em_memtoreg;
  logic [2:0]        em_funct3;
  logic [4:0]        em_rd;
  logic [31:0]       em_alu, em_b;

  logic              timeout_hit, new_mem, em_mem;
  logic [1:0]        lane;
  logic [3:0]        be_lanes;
  logic [31:0]       lane_word, load_ext;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  logic              wb_valid_n, wb_rw_n, mis_n, tmo_n;
  logic [4:0]        wb_rd_n;
  logic [31:0]       wb_data_n;

  // Byte accesses never misalign; halfwords need a[0]=0; everything else is a word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  assign EX_MEM_ALU      = em_alu;
  assign EX_MEM_Rd       = em_rd;
  assign EX_MEM_RegWrite = em_valid & em_regwrite;

  assign lane      = em_alu[1:0];
  assign dmem_req  = (state == ACCESS);
  assign dmem_we   = em_memwrite;
  assign dmem_addr = {em_alu[31:2], 2'b00};
  assign dmem_be   = dmem_req ? be_lanes : 4'b0000;
  assign em_mem    = em_memread | em_memwrite;

  // Store lane steering and load lane selection/extension.
  always_comb begin
    be_lanes   = 4'b1111;
    dmem_wdata = em_b;
    case (em_funct3[1:0])
      2'b00: begin
        be_lanes   = 4'b0001 << lane;
        dmem_wdata = {4{em_b[7:0]}};
      end
      2'b01: begin
        be_lanes   = 4'b0011 << {lane[1], 1'b0};
        dmem_wdata = {2{em_b[15:0]}};
      end
      default: ;
    endcase

    lane_word = dmem_rdata >> {lane, 3'b000};
    ld_byte   = lane_word[7:0];
    ld_half   = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (em_funct3)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_ext = {24'h000000, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_ext = {16'h0000, ld_half};
      default: load_ext = dmem_rdata;
    endcase
  end

  // Next state, timeout counter, stall and MEM/WB next values.
  always_comb begin
    state_next = state;
    count_next = count;
    wb_valid_n = 1'b0;
    wb_rw_n    = 1'b0;
    wb_rd_n    = MEM_WB_Rd;
    wb_data_n  = MEM_WB_Data;
    mis_n      = 1'b0;
    tmo_n      = 1'b0;

    timeout_hit = TMO_EN && (state == ACCESS) && (count == CNT_LAST) && !dmem_ready;
    mem_stall   = (state == ACCESS) && !dmem_ready && !timeout_hit;
    new_mem     = ex_valid && (MemRead || MemWrite) && !is_misaligned(Funct3, ALUResult[1:0]);

    if (!mem_stall) begin
      state_next = new_mem ? ACCESS : IDLE;
    end
    if (!mem_stall && new_mem) begin
      count_next = '0;
    end else if (state == ACCESS && !dmem_ready) begin
      count_next = count + CNT_W'(1);
    end

    if (state == ACCESS) begin
      if (dmem_ready) begin
        wb_valid_n = 1'b1;
        wb_rw_n    = em_regwrite;
        wb_rd_n    = em_rd;
        wb_data_n  = em_memtoreg ? load_ext : em_alu;
      end else if (timeout_hit) begin
        wb_valid_n = 1'b1;
        wb_rd_n    = em_rd;
        wb_data_n  = em_memtoreg ? 32'h0 : em_alu;
        tmo_n      = 1'b1;
      end
    end else if (em_valid) begin
      wb_valid_n = 1'b1;
      wb_rd_n    = em_rd;
      wb_data_n  = em_alu;
      if (em_mem && is_misaligned(em_funct3, lane)) begin
        mis_n     = 1'b1;
        wb_data_n = em_memtoreg ? 32'h0 : em_alu;
      end else begin
        wb_rw_n = em_regwrite;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      count           <= '0;
      em_valid        <= 1'b0;
      em_memread      <= 1'b0;
      em_memwrite     <= 1'b0;
      em_regwrite     <= 1'b0;
      em_memtoreg     <= 1'b0;
      em_funct3       <= 3'b000;
      em_rd           <= 5'd0;
      em_alu          <= 32'h0;
      em_b            <= 32'h0;
      MEM_WB_valid    <= 1'b0;
      MEM_WB_RegWrite <= 1'b0;
      MEM_WB_Rd       <= 5'd0;
      MEM_WB_Data     <= 32'h0;
      misalign_err    <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (!mem_stall) begin
        em_valid    <= ex_valid;
        em_memread  <= MemRead;
        em_memwrite <= MemWrite;
        em_regwrite <= RegWrite;
        em_memtoreg <= MemtoReg;
        em_funct3   <= Funct3;
        em_rd       <= Rd_in;
        em_alu      <= ALUResult;
        em_b        <= ForwardedB;
      end
      MEM_WB_valid    <= wb_valid_n;
      MEM_WB_RegWrite <= wb_rw_n;
      MEM_WB_Rd       <= wb_rd_n;
      MEM_WB_Data     <= wb_data_n;
      misalign_err    <= mis_n;
      timeout_err     <= tmo_n;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM/WB records are queued at issue
// and retired whenever the stage reports a valid MEM/WB write.
module tb_mem_stage;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, RegWrite = 1'b0, MemtoReg = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [4:0]  Rd_in = 5'd0;
  logic [31:0] ALUResult = 32'h0, ForwardedB = 32'h0;
  logic        mem_stall;
  logic [31:0] EX_MEM_ALU;
  logic [4:0]  EX_MEM_Rd;
  logic        EX_MEM_RegWrite;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        MEM_WB_valid, MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_Rd;
  logic [31:0] MEM_WB_Data;
  logic        misalign_err, timeout_err;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
    logic        tmo;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rdata_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          stall_cnt = 0;
  int          wait_cycles = 0;
  int          wait_cnt = 0;

  mem_stage #(.DMEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Funct3(Funct3), .Rd_in(Rd_in),
    .ALUResult(ALUResult), .ForwardedB(ForwardedB), .mem_stall(mem_stall),
    .EX_MEM_ALU(EX_MEM_ALU), .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .MEM_WB_valid(MEM_WB_valid), .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_Rd(MEM_WB_Rd),
    .MEM_WB_Data(MEM_WB_Data), .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ext_model(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] a);
    logic [7:0]  bt;
    logic [15:0] h;
    case (a)
      2'd0:    bt = w[7:0];
      2'd1:    bt = w[15:8];
      2'd2:    bt = w[23:16];
      default: bt = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{bt[7]}}, bt};
      3'b100:  return {24'h0, bt};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Memory responder: holds ready low for wait_cycles request cycles, then completes.
  always begin
    @(posedge clk);
    #1;
    if (dmem_req) begin
      if (wait_cnt < wait_cycles) begin
        dmem_ready = 1'b0;
        wait_cnt++;
      end else begin
        dmem_ready = 1'b1;
        wait_cnt = 0;
        if (!dmem_we) dmem_rdata = (rdata_q.size() != 0) ? rdata_q.pop_front() : 32'h0;
      end
    end else begin
      dmem_ready = 1'b0;
      wait_cnt = 0;
    end
  end

  // Scoreboard retirement on every MEM/WB write.
  always @(negedge clk) begin
    if (mem_stall === 1'b1) stall_cnt++;
    if (MEM_WB_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_rd", 32'(MEM_WB_Rd), 32'(e.rd));
        check("wb_regwrite", 32'(MEM_WB_RegWrite), 32'(e.rw));
        if (e.chk_data) check("wb_data", MEM_WB_Data, e.data);
        check("wb_misalign_err", 32'(misalign_err), 32'(e.mis));
        check("wb_timeout_err", 32'(timeout_err), 32'(e.tmo));
      end
    end else if (misalign_err === 1'b1 || timeout_err === 1'b1) begin
      check("err_without_wb", 32'({misalign_err, timeout_err}), 32'd0);
    end
  end

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  // Drive one EX instruction (called at posedge+1), queue its expectation, wait for capture.
  task automatic send(input logic mr, input logic mw, input logic rw, input logic m2r,
                      input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                      input logic [31:0] b, input logic [31:0] rdata);
    exp_t e;
    logic mis, memop, seen;
    memop = mr | mw;
    case (f3)
      3'b000, 3'b100: mis = 1'b0;
      3'b001, 3'b101: mis = alu[0];
      default:        mis = (alu[1:0] != 2'b00);
    endcase
    mis        = mis & memop;
    e.rd       = rd;
    e.rw       = rw;
    e.data     = alu;
    e.chk_data = 1'b1;
    e.mis      = 1'b0;
    e.tmo      = 1'b0;
    if (mis) begin
      e.rw = 1'b0; e.mis = 1'b1; e.chk_data = 1'b0;
    end else if (memop && wait_cycles >= int'(TMO)) begin
      e.rw = 1'b0; e.tmo = 1'b1; e.data = m2r ? 32'h0 : alu;
    end else if (memop) begin
      e.data = m2r ? ext_model(rdata, f3, alu[1:0]) : alu;
      if (mr) rdata_q.push_back(rdata);
    end
    exp_q.push_back(e);
    ex_valid = 1'b1; MemRead = mr; MemWrite = mw; RegWrite = rw; MemtoReg = m2r;
    Funct3 = f3; Rd_in = rd; ALUResult = alu; ForwardedB = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      seen = mem_stall;
      @(posedge clk);
      if (!seen) break;
      if (i == 199) check("capture_timeout", 32'd1, 32'd0);
    end
    #1;
    ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0; MemtoReg = 1'b0;
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_mem_stall"}, 32'(mem_stall), 32'd0);
    check({p, "_dmem_req"}, 32'(dmem_req), 32'd0);
    check({p, "_dmem_we"}, 32'(dmem_we), 32'd0);
    check({p, "_dmem_addr"}, dmem_addr, 32'd0);
    check({p, "_dmem_wdata"}, dmem_wdata, 32'd0);
    check({p, "_dmem_be"}, 32'(dmem_be), 32'd0);
    check({p, "_ex_mem"}, 32'({EX_MEM_Rd, EX_MEM_RegWrite}), 32'd0);
    check({p, "_ex_mem_alu"}, EX_MEM_ALU, 32'd0);
    check({p, "_mem_wb"}, 32'({MEM_WB_valid, MEM_WB_RegWrite, MEM_WB_Rd}), 32'd0);
    check({p, "_mem_wb_data"}, MEM_WB_Data, 32'd0);
    check({p, "_errs"}, 32'({misalign_err, timeout_err}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    logic flag;
    logic [2:0]  ld_f3[4]   = '{3'b000, 3'b101, 3'b001, 3'b100};
    logic [31:0] ld_addr[4] = '{32'h2001, 32'h2002, 32'h2002, 32'h2003};
    logic [31:0] ld_data[4] = '{32'h0000_8000, 32'hBEEF_0000, 32'h8001_0000, 32'hC300_0000};
    logic [2:0]  st_f3[3]   = '{3'b001, 3'b010, 3'b000};
    logic [31:0] st_addr[3] = '{32'h4002, 32'h4004, 32'h4001};
    logic [31:0] st_b[3]    = '{32'h1234_CAFE, 32'hDEAD_BEEF, 32'h0000_005A};
    logic [3:0]  st_be[3]   = '{4'b1100, 4'b1111, 4'b0010};
    logic [31:0] st_wd[3]   = '{32'hCAFE_CAFE, 32'hDEAD_BEEF, 32'h5A5A_5A5A};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    sync;
    reset = 1'b0;

    // ALU pass-through: EX/MEM after one edge, MEM/WB after two.
    base = stall_cnt;
    send(1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 5'd5, 32'h1234, 32'h0, 32'h0);
    check("alu_ex_mem_alu", EX_MEM_ALU, 32'h1234);
    check("alu_ex_mem_rd", 32'(EX_MEM_Rd), 32'd5);
    check("alu_ex_mem_rw", 32'(EX_MEM_RegWrite), 32'd1);
    @(negedge clk);
    check("alu_wb_early", 32'(MEM_WB_valid), 32'd0);
    @(negedge clk);
    check("alu_wb_lat", 32'(MEM_WB_valid), 32'd1);
    check("alu_stall", 32'(stall_cnt - base), 32'd0);

    // SB with three wait states.
    sync;
    wait_cycles = 3;
    base = stall_cnt;
    send(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 5'd0, 32'h1003, 32'h0000_00AB, 32'h0);
    n = 0;
    flag = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!dmem_req) break;
      if (i == 0) begin
        check("sb_addr", dmem_addr, 32'h1000);
        check("sb_be", 32'(dmem_be), 32'h8);
        check("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        check("sb_we", 32'(dmem_we), 32'd1);
      end
      n++;
      if (dmem_addr != 32'h1000 || dmem_be != 4'b1000 || dmem_wdata != 32'hABAB_ABAB) flag = 1'b1;
    end
    check("sb_req_cycles", 32'(n), 32'd4);
    check("sb_stable", 32'(flag), 32'd0);
    check("sb_stall", 32'(stall_cnt - base), 32'd3);

    // Back-to-back loads with zero wait states.
    sync;
    wait_cycles = 0;
    base = stall_cnt;
    for (int i = 0; i < 4; i++)
      send(1'b1, 1'b0, 1'b1, 1'b1, ld_f3[i], 5'(6 + i), ld_addr[i], 32'h0, ld_data[i]);
    @(negedge clk);
    check("ld_req_held", 32'(dmem_req), 32'd1);
    @(negedge clk);
    check("ld_req_drop", 32'(dmem_req), 32'd0);
    check("ld_stall", 32'(stall_cnt - base), 32'd0);

    // Store lane steering.
    for (int i = 0; i < 3; i++) begin
      sync;
      send(1'b0, 1'b1, 1'b0, 1'b0, st_f3[i], 5'd0, st_addr[i], st_b[i], 32'h0);
      @(negedge clk);
      check("st_be", 32'(dmem_be), 32'(st_be[i]));
      check("st_wdata", dmem_wdata, st_wd[i]);
      check("st_addr", dmem_addr, {st_addr[i][31:2], 2'b00});
    end

    // Misaligned LW and SW: no request, no stall.
    sync;
    base = stall_cnt;
    send(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 5'd8, 32'h3002, 32'h0, 32'h0);
    flag = dmem_req;
    send(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 5'd0, 32'h3001, 32'h0, 32'h0);
    flag = flag | dmem_req;
    repeat (3) begin
      @(negedge clk);
      flag = flag | dmem_req;
    end
    check("mis_no_req", 32'(flag), 32'd0);
    check("mis_stall", 32'(stall_cnt - base), 32'd0);

    // Timeout: ready stuck low; a queued ALU op proceeds after the timeout.
    sync;
    wait_cycles = 100;
    base = stall_cnt;
    send(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 5'd9, 32'h5000, 32'h0, 32'h0);
    send(1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 5'd10, 32'h77, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("tmo_stall", 32'(stall_cnt - base), 32'd3);

    // Reset while a load is outstanding.
    sync;
    send(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 5'd11, 32'h6000, 32'h0, 32'h0);
    @(negedge clk);
    check("rstacc_req_before", 32'(dmem_req), 32'd1);
    sync;
    reset = 1'b1;
    sync;
    reset = 1'b0;
    exp_q.delete();
    wait_cycles = 0;
    @(negedge clk);
    check_reset_outputs("rstacc");
    sync;
    send(1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 5'd12, 32'h55, 32'h0, 32'h0);

    repeat (4) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
